// File: rtl/div_pkg.sv
// Shared types and constants for the signed sequential divider.
package div_pkg;

  // Controller states: operand capture, iterative subtraction, sign fix-up, result pulse
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 8;
  localparam int DIV_MAX_WIDTH     = 64;

  // Quotient reported for a zero divisor: all ones in the low 'width' bits
  function automatic logic [DIV_MAX_WIDTH-1:0] dbz_quotient(input int width);
    logic [DIV_MAX_WIDTH-1:0] q;
    q = '0;
    for (int i = 0; i < DIV_MAX_WIDTH; i++) begin
      if (i < width) q[i] = 1'b1;
    end
    return q;
  endfunction

endpackage

// File: rtl/twos_negate.sv
// Conditional two's-complement negation: result = neg ? -value : value.
module twos_negate #(
  parameter int W = 8
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/signed_seq_divider.sv
// Signed restoring divider, one quotient bit per clock, start/busy/done handshake.
// Latency from accepted start to done is WIDTH+2 cycles for every operand pair.
// Optional build macro DIV_OVF_DETECT_EN: flags MIN / -1 on the overflow output;
// without it overflow is tied low.
module signed_seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int                       CW         = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]            LAST_ITER  = CW'(WIDTH - 1);
  localparam logic [DIV_MAX_WIDTH-1:0] DBZ_Q_FULL = dbz_quotient(WIDTH);
  localparam logic [WIDTH-1:0]         DBZ_Q      = DBZ_Q_FULL[WIDTH-1:0];

  div_state_t       state;
  logic [CW-1:0]    iter;
  logic [WIDTH-1:0] dvd_r;      // raw dividend: sign source and zero-divisor remainder
  logic             dvs_neg;
  logic             dbz_r;
  logic [WIDTH:0]   dvs_mag_r;  // |divisor| needs WIDTH+1 bits only when read as signed
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH:0]   dvs_mag;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] quo_signed;
  logic [WIDTH-1:0] rem_signed;

  // |dividend| read as unsigned WIDTH bits is exact, including 2^(WIDTH-1) for MIN
  twos_negate #(.W(WIDTH)) u_dvd_mag (
    .value (dividend),
    .neg   (dividend[WIDTH-1]),
    .result(dvd_mag)
  );

  twos_negate #(.W(WIDTH + 1)) u_dvs_mag (
    .value ({divisor[WIDTH-1], divisor}),
    .neg   (divisor[WIDTH-1]),
    .result(dvs_mag)
  );

  twos_negate #(.W(WIDTH)) u_quo_sign (
    .value (quo),
    .neg   (dvd_r[WIDTH-1] ^ dvs_neg),
    .result(quo_signed)
  );

  twos_negate #(.W(WIDTH)) u_rem_sign (
    .value (rem),
    .neg   (dvd_r[WIDTH-1]),
    .result(rem_signed)
  );

  // Partial remainder after the left shift, and whether |divisor| can be taken from it
  assign shifted = {rem, quo[WIDTH-1]};
  assign fits    = (shifted >= dvs_mag_r);

  // Controller and datapath: capture, WIDTH restoring steps, sign fix, done pulse
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every register here sees pre-edge values of the others.
    if (!rst_n) begin
      state       <= IDLE;
      iter        <= '0;
      dvd_r       <= '0;
      dvs_neg     <= 1'b0;
      dbz_r       <= 1'b0;
      dvs_mag_r   <= '0;
      rem         <= '0;
      quo         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd_r       <= dividend;
            dvs_neg     <= divisor[WIDTH-1];
            dbz_r       <= (divisor == '0);
            dvs_mag_r   <= dvs_mag;
            quo         <= dvd_mag;
            rem         <= '0;
            iter        <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= CALC;
          end
        end
        CALC: begin
          // Remainder stays below |divisor| <= 2^(WIDTH-1), so WIDTH bits always hold it
          quo  <= {quo[WIDTH-2:0], fits};
          rem  <= fits ? WIDTH'(shifted - dvs_mag_r) : shifted[WIDTH-1:0];
          iter <= iter + CW'(1);
          if (iter == LAST_ITER) state <= SIGN;
        end
        SIGN: begin
          quotient    <= dbz_r ? DBZ_Q : quo_signed;
          remainder   <= dbz_r ? dvd_r : rem_signed;
          div_by_zero <= dbz_r;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIV_OVF_DETECT_EN
  logic ovf_r;
  logic ovf_hit;

  assign ovf_hit = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);

  // MIN / -1 is noted at acceptance and published together with the results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_r    <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      ovf_r    <= ovf_hit;
      overflow <= 1'b0;
    end else if (state == SIGN) begin
      overflow <= ovf_r;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_signed_seq_divider.sv
// Self-checking bench for signed_seq_divider (WIDTH=8): directed cases plus
// random operands checked against plain integer division.
module tb_signed_seq_divider;

  localparam int W = 8;
`ifdef DIV_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  int           n;
  int           cnt;
  int           first_done;
  int           second_done;
  int           sel;
  logic [W-1:0] ra, rb;
  logic [W-1:0] eq_a, er_a, eq_b, er_b;
  logic         ez_a, eo_a, ez_b, eo_b;

  always #5 clk = ~clk;

  signed_seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer division truncating toward zero, with the zero-divisor rule
  task automatic model(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic z, output logic o);
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
      o = 1'b0;
    end else begin
      q = W'(ai / bi);
      r = W'(ai % bi);
      z = 1'b0;
      o = OVF_EN && (ai == -(2 ** (W - 1))) && (bi == -1);
    end
  endtask

  // One division; optionally pulses start again in cycle 'poke' while busy
  task automatic run_div(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                         input int poke);
    int           k;
    logic [W-1:0] eq, er;
    logic         ez, eo;
    model(a, b, eq, er, ez, eo);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    k = 1;
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    while (!done && k < 40) begin
      check("busy_during_calc", 32'(busy), 1);
      start    = (k == poke);
      dividend = W'($urandom);
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", 32'(done), 1);
    check("latency", k, W + 2);
    check("busy_at_done", 32'(busy), 0);
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_by_zero", 32'(div_by_zero), 32'(ez));
    check("overflow", 32'(overflow), 32'(eo));
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("quotient_held", 32'(quotient), 32'(eq));
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_quotient", 32'(quotient), 0);
    check("rst_remainder", 32'(remainder), 0);
    check("rst_dbz", 32'(div_by_zero), 0);
    check("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;

    // Sign combinations
    run_div(8'sd7, 8'sd2, -1);
    run_div(-8'sd7, 8'sd2, -1);
    run_div(8'sd7, -8'sd2, -1);
    run_div(-8'sd7, -8'sd2, -1);

    // Divide by zero, then flags clear on the following division
    run_div(8'sd5, 8'sd0, -1);
    run_div(8'sd6, 8'sd3, -1);

    // MIN / -1 wraps
    run_div(8'h80, 8'hFF, -1);
    run_div(8'sd1, 8'sd1, -1);

    // start while busy is ignored and not queued
    run_div(8'sd100, 8'sd7, 4);
    cnt = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) cnt++;
    end
    check("no_queued_done", cnt, 0);

    // Reset during CALC abandons the division
    @(negedge clk);
    start    = 1'b1;
    dividend = W'(50);
    divisor  = W'(3);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_quotient", 32'(quotient), 0);
    check("midrst_remainder", 32'(remainder), 0);
    check("midrst_dbz", 32'(div_by_zero), 0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) cnt++;
    end
    check("midrst_no_done", cnt, 0);
    run_div(8'sd9, 8'sd4, -1);

    // start held high: back-to-back divisions every W+3 cycles
    model(W'(20), W'(-3), eq_a, er_a, ez_a, eo_a);
    model(W'(-45), W'(6), eq_b, er_b, ez_b, eo_b);
    @(negedge clk);
    start    = 1'b1;
    dividend = W'(20);
    divisor  = W'(-3);
    @(posedge clk);
    @(negedge clk);
    dividend    = W'(-45);
    divisor     = W'(6);
    n           = 1;
    first_done  = 0;
    second_done = 0;
    while (n < 40 && second_done == 0) begin
      if (done) begin
        if (first_done == 0) begin
          first_done = n;
          check("b2b_q1", 32'(quotient), 32'(eq_a));
          check("b2b_r1", 32'(remainder), 32'(er_a));
        end else begin
          second_done = n;
          check("b2b_q2", 32'(quotient), 32'(eq_b));
          check("b2b_r2", 32'(remainder), 32'(er_b));
          start = 1'b0;
        end
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b_first_latency", first_done, W + 2);
    check("b2b_second_latency", second_done, 2 * W + 5);
    repeat (3) @(negedge clk);

    // Random operands with extra weight on zero divisor and MIN
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      ra  = W'($urandom);
      rb  = W'($urandom);
      if (sel == 0) rb = '0;
      else if (sel == 1) begin
        ra = 8'h80;
        rb = '1;
      end else if (sel == 2) ra = 8'h80;
      run_div(ra, rb, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
